pipelined_cla_adder: RTL



---
 rtl/pipelined_cla_pkg.sv | 19 +
 rtl/pipelined_cla_adder_cla_slice.sv | 71 +++++++
 rtl/pipelined_cla_adder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_pkg.sv
// Shared defaults and configuration helpers for the pipelined carry-lookahead adder.
package pipelined_cla_pkg;

    localparam int unsigned DefWidth  = 64;
    localparam int unsigned DefStages = 4;
    localparam int unsigned DefGroup  = 4;

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages,
                                  input int unsigned group);
        return (stages != 0) && (group != 0) && (width % stages == 0) &&
               ((width / stages) % group == 0);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_slice.sv
// Combinational carry-lookahead adder for one slice: bit g/p, group G/P,
// and a fully expanded lookahead network across groups.
module cla_slice #(
    parameter int unsigned SLICE = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb
);

    localparam int unsigned NumGroups = SLICE / GROUP;

    logic [SLICE-1:0]     g;
    logic [SLICE-1:0]     p;
    logic [NumGroups-1:0] grp_g;
    logic [NumGroups-1:0] grp_p;
    logic [NumGroups:0]   grp_c;
    logic [SLICE:0]       c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        grp_g = '0;
        grp_p = '1;
        for (int j = 0; j < NumGroups; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                grp_g[j] = g[j*GROUP+i] | (p[j*GROUP+i] & grp_g[j]);
                grp_p[j] = grp_p[j] & p[j*GROUP+i];
            end
        end
    end

    // Each group carry is a flat sum of products, independent of lower group carries.
    always_comb begin
        logic term;
        term     = 1'b0;
        grp_c    = '0;
        grp_c[0] = ci;
        for (int j = 0; j < NumGroups; j++) begin
            term = ci;
            for (int m = 0; m <= j; m++) term = term & grp_p[m];
            grp_c[j+1] = term;
            for (int k = 0; k <= j; k++) begin
                term = grp_g[k];
                for (int m = k + 1; m <= j; m++) term = term & grp_p[m];
                grp_c[j+1] = grp_c[j+1] | term;
            end
        end
    end

    always_comb begin
        c = '0;
        for (int j = 0; j < NumGroups; j++) begin
            c[j*GROUP] = grp_c[j];
            for (int i = 0; i < GROUP - 1; i++) begin
                c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
            end
        end
        c[SLICE] = grp_c[NumGroups];
    end

    assign s     = p ^ c[SLICE-1:0];
    assign co    = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Streaming adder/subtractor: one CLA slice per pipeline stage, carry registered
// between stages, global stall driven by the output handshake.
module pipelined_cla_adder
    import pipelined_cla_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned STAGES = DefStages,
    parameter int unsigned GROUP  = DefGroup
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned SLICE = slice_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES, GROUP)) begin : g_cfg_check
        $error("pipelined_cla_adder: WIDTH/STAGES/GROUP do not divide evenly");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;
    assign b_eff    = sub ? ~b : b;
    assign cin_eff  = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             src_valid;
        logic             src_ci;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;

        logic             valid_q, valid_d;
        logic             carry_q, carry_d;
        logic [WIDTH-1:0] sum_q, sum_d;
        logic [WIDTH-1:0] opa_q, opa_d;
        logic [WIDTH-1:0] opb_q, opb_d;

        logic [SLICE-1:0] slice_s;
        logic             slice_co;
        logic             slice_cmsb;

        if (k == 0) begin : g_first
            assign src_valid = in_valid;
            assign src_ci    = cin_eff;
            assign src_a     = a;
            assign src_b     = b_eff;
            assign src_sum   = '0;
        end else begin : g_next
            assign src_valid = g_stage[k-1].valid_q;
            assign src_ci    = g_stage[k-1].carry_q;
            assign src_a     = g_stage[k-1].opa_q;
            assign src_b     = g_stage[k-1].opb_q;
            assign src_sum   = g_stage[k-1].sum_q;
        end

        cla_slice #(
            .SLICE(SLICE),
            .GROUP(GROUP)
        ) u_slice (
            .a    (src_a[k*SLICE +: SLICE]),
            .b    (src_b[k*SLICE +: SLICE]),
            .ci   (src_ci),
            .s    (slice_s),
            .co   (slice_co),
            .c_msb(slice_cmsb)
        );

        // Data registers only load on a real beat; bubbles just clear valid.
        always_comb begin
            valid_d = valid_q;
            carry_d = carry_q;
            sum_d   = sum_q;
            opa_d   = opa_q;
            opb_d   = opb_q;
            if (advance) begin
                valid_d = src_valid;
                if (src_valid) begin
                    sum_d                   = src_sum;
                    sum_d[k*SLICE +: SLICE] = slice_s;
                    carry_d                 = slice_co;
                    opa_d                   = src_a;
                    opb_d                   = src_b;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
                opa_q   <= '0;
                opb_q   <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
                opa_q   <= opa_d;
                opb_q   <= opb_d;
            end
        end
    end

    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (advance && g_stage[STAGES-1].src_valid) begin
            ovf_d  = g_stage[STAGES-1].slice_co ^ g_stage[STAGES-1].slice_cmsb;
            zero_d = (g_stage[STAGES-1].sum_d == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
